// File: rtl/sram_burst_ctrl_if.sv
// Command, write-stream, read-stream, status and SRAM-port signals of sram_burst_ctrl.
// The controller connects through the slave modport; its environment uses master.
interface sram_burst_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 20
);
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic                  i_cmd_write;
  logic [ADDR_WIDTH-1:0] i_cmd_addr;
  logic [LEN_WIDTH-1:0]  i_cmd_len;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  i_wr_valid;
  logic                  o_wr_ready;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_rd_valid;
  logic                  i_rd_ready;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_sram_wren;
  logic [ADDR_WIDTH-1:0] o_sram_addr;
  logic [DATA_WIDTH-1:0] o_sram_wdata;
  logic [DATA_WIDTH-1:0] i_sram_rdata;

  modport slave (
    input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len,
    input  i_wr_data, i_wr_valid, i_rd_ready, i_sram_rdata,
    output o_cmd_ready, o_wr_ready, o_rd_data, o_rd_valid,
    output o_busy, o_done, o_sram_wren, o_sram_addr, o_sram_wdata
  );

  modport master (
    output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len,
    output i_wr_data, i_wr_valid, i_rd_ready, i_sram_rdata,
    input  o_cmd_ready, o_wr_ready, o_rd_data, o_rd_valid,
    input  o_busy, o_done, o_sram_wren, o_sram_addr, o_sram_wdata
  );
endinterface

// File: rtl/sram_burst_ctrl.sv
// Burst controller for a single-port SRAM: streams write bursts into memory and
// read bursts out of it through a one-word output register, with wrapping addresses.
module sram_burst_ctrl #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 20
) (
  input  logic               i_clk,
  input  logic               i_rst,
  sram_burst_ctrl_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, WR, RD, RD_DRAIN, DONE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [LEN_WIDTH-1:0]  rem_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  wren_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  cmd_fire;
  logic                  wr_fire;
  logic                  rd_capture;
  logic                  rd_fire;
  logic                  last_beat;

  assign cmd_fire   = (state == IDLE) && bus.i_cmd_valid;
  assign wr_fire    = (state == WR) && bus.i_wr_valid;
  // The output register refills whenever it is empty or being drained this cycle.
  assign rd_capture = (state == RD) && (!rd_valid_q || bus.i_rd_ready);
  assign rd_fire    = rd_valid_q && bus.i_rd_ready;
  assign last_beat  = (rem_cnt == LEN_WIDTH'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.i_cmd_valid) begin
          if (bus.i_cmd_len == '0) state_nxt = DONE;
          else if (bus.i_cmd_write) state_nxt = WR;
          else                      state_nxt = RD;
        end
      end
      WR:       if (wr_fire && last_beat) state_nxt = DONE;
      RD:       if (rd_capture && last_beat) state_nxt = RD_DRAIN;
      RD_DRAIN: if (rd_fire) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Reads address the SRAM combinationally from the counter; writes use the registered beat address.
  always_comb begin
    bus.o_cmd_ready = 1'b0;
    bus.o_wr_ready  = 1'b0;
    bus.o_busy      = 1'b1;
    bus.o_done      = 1'b0;
    bus.o_sram_addr = wr_addr_q;
    case (state)
      IDLE: begin
        bus.o_cmd_ready = 1'b1;
        bus.o_busy      = 1'b0;
      end
      WR:      bus.o_wr_ready  = 1'b1;
      RD:      bus.o_sram_addr = addr_cnt;
      DONE:    bus.o_done      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_cnt   <= '0;
      rem_cnt    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wren_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wren_q <= 1'b0;
      if (cmd_fire) begin
        addr_cnt <= bus.i_cmd_addr;
        rem_cnt  <= bus.i_cmd_len;
      end
      if (wr_fire) begin
        wren_q    <= 1'b1;
        wr_addr_q <= addr_cnt;
        wr_data_q <= bus.i_wr_data;
        addr_cnt  <= addr_cnt + ADDR_WIDTH'(1);
        rem_cnt   <= rem_cnt - LEN_WIDTH'(1);
      end
      if (rd_capture) begin
        rd_data_q  <= bus.i_sram_rdata;
        rd_valid_q <= 1'b1;
        addr_cnt   <= addr_cnt + ADDR_WIDTH'(1);
        rem_cnt    <= rem_cnt - LEN_WIDTH'(1);
      end else if (rd_fire) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_sram_wren  = wren_q;
  assign bus.o_sram_wdata = wr_data_q;
  assign bus.o_rd_data    = rd_data_q;
  assign bus.o_rd_valid   = rd_valid_q;
endmodule
